// File: rtl/parking_pkg.sv
// Shared types and default sizing for the parking barrier controller.
package parking_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OPEN  = 2'd1,
      CLOSE = 2'd2
   } gate_state_t;

   typedef enum logic {
      LANE_ENTRY = 1'b0,
      LANE_EXIT  = 1'b1
   } lane_t;

   localparam int DEF_CAPACITY    = 8;
   localparam int DEF_CNT_W       = 4;
   localparam int DEF_OPEN_TICKS  = 20;
   localparam int DEF_CLOSE_TICKS = 4;
   localparam int DEF_TICK_W      = 5;

endpackage

// File: rtl/gate_arbiter.sv
// Two-way round-robin between the entry and exit lanes.
// When both lanes are eligible the lane opposite the last one served wins.
module gate_arbiter
   import parking_pkg::*;
(
   input  logic  elig_entry,
   input  logic  elig_exit,
   input  lane_t last_served,
   output logic  grant_valid,
   output logic  grant_exit
);

   logic both;

   assign both        = elig_entry && elig_exit;
   assign grant_valid = elig_entry || elig_exit;
   assign grant_exit  = both ? (last_served == LANE_ENTRY) : elig_exit;

endmodule

// File: rtl/parking_gate_ctrl.sv
// Parking barrier sequencer: request latching, round-robin grant, gate
// open/close timing on the 2 Hz tick, and lot occupancy tracking.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | barrier down, waiting for an eligible pending request
//   OPEN  | barrier up, waiting for car_passed or OPEN_TICKS ticks
//   CLOSE | barrier down, guard time of CLOSE_TICKS ticks before next grant
module parking_gate_ctrl
   import parking_pkg::*;
#(
   parameter int CAPACITY    = DEF_CAPACITY,
   parameter int CNT_W       = DEF_CNT_W,
   parameter int OPEN_TICKS  = DEF_OPEN_TICKS,
   parameter int CLOSE_TICKS = DEF_CLOSE_TICKS,
   parameter int TICK_W      = DEF_TICK_W
) (
   input  logic             clk_40MHz,
   input  logic             reset_n,
   input  logic             tick,
   input  logic             entry_req,
   input  logic             exit_req,
   input  logic             car_passed,
   output logic             door_trigger,
   output logic             gate_open,
   output logic             dir_exit,
   output logic [CNT_W-1:0] occupancy,
   output logic             full,
   output logic             timeout,
   output logic             reject
);

   gate_state_t       state;
   logic [TICK_W-1:0] tcnt;
   lane_t             last_served;
   logic              entry_pend;
   logic              exit_pend;
   logic              empty;
   logic              elig_entry;
   logic              elig_exit;
   logic              grant_valid;
   logic              grant_exit;
   logic              grant_now;
   logic              tick_last;

   assign full       = (occupancy == CNT_W'(CAPACITY));
   assign empty      = (occupancy == '0);
   assign elig_entry = entry_pend && !full;
   assign elig_exit  = exit_pend && !empty;
   assign grant_now  = (state == IDLE) && grant_valid;
   // Treat 0 like 1 so a corrupted counter can never stall the gate.
   assign tick_last  = (tcnt <= TICK_W'(1));

   gate_arbiter u_arbiter (
      .elig_entry  (elig_entry),
      .elig_exit   (elig_exit),
      .last_served (last_served),
      .grant_valid (grant_valid),
      .grant_exit  (grant_exit)
   );

   // Latch lane requests; refuse entry when full and exit when empty.
   // A request on a lane whose flag is already set is absorbed silently.
   always_ff @(posedge clk_40MHz) begin
      if (!reset_n) begin
         entry_pend <= 1'b0;
         exit_pend  <= 1'b0;
         reject     <= 1'b0;
      end else begin
         reject <= (entry_req && !entry_pend && full) ||
                   (exit_req  && !exit_pend  && empty);
         if (grant_now && !grant_exit)
            entry_pend <= 1'b0;
         else if (entry_req && !full)
            entry_pend <= 1'b1;
         if (grant_now && grant_exit)
            exit_pend <= 1'b0;
         else if (exit_req && !empty)
            exit_pend <= 1'b1;
      end
   end

   // Gate FSM with tick down-counter and saturating occupancy counter.
   always_ff @(posedge clk_40MHz) begin
      if (!reset_n) begin
         state        <= IDLE;
         tcnt         <= '0;
         last_served  <= LANE_EXIT;
         occupancy    <= '0;
         dir_exit     <= 1'b0;
         gate_open    <= 1'b0;
         door_trigger <= 1'b0;
         timeout      <= 1'b0;
      end else begin
         door_trigger <= 1'b0;
         timeout      <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_valid) begin
                  state        <= OPEN;
                  tcnt         <= TICK_W'(OPEN_TICKS);
                  dir_exit     <= grant_exit;
                  last_served  <= grant_exit ? LANE_EXIT : LANE_ENTRY;
                  gate_open    <= 1'b1;
                  door_trigger <= 1'b1;
               end
            end
            OPEN: begin
               if (car_passed) begin
                  if (!dir_exit) begin
                     if (!full)
                        occupancy <= occupancy + CNT_W'(1);
                  end else if (!empty) begin
                     occupancy <= occupancy - CNT_W'(1);
                  end
                  state     <= CLOSE;
                  tcnt      <= TICK_W'(CLOSE_TICKS);
                  gate_open <= 1'b0;
               end else if (tick) begin
                  if (tick_last) begin
                     state     <= CLOSE;
                     tcnt      <= TICK_W'(CLOSE_TICKS);
                     gate_open <= 1'b0;
                     timeout   <= 1'b1;
                  end else begin
                     tcnt <= tcnt - TICK_W'(1);
                  end
               end
            end
            CLOSE: begin
               if (tick) begin
                  if (tick_last) begin
                     state <= IDLE;
                     tcnt  <= '0;
                  end else begin
                     tcnt <= tcnt - TICK_W'(1);
                  end
               end
            end
            default: begin
               state     <= IDLE;
               gate_open <= 1'b0;
            end
         endcase
      end
   end

endmodule
